// File: rtl/decode_forwarding_pkg.sv
// Shared types and constants for the RV32IM decode and operand-forwarding slice.
// Latency: none. This package holds only types, constants and one pure helper function.
// Backpressure: none. The package has no flow control.
package decode_forwarding_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
    localparam logic [31:0] INSTR_ECALL   = 32'h0000_0073;

    typedef enum logic [1:0] {
        BYP_NONE = 2'd0,
        BYP_EX   = 2'd1,
        BYP_MEM  = 2'd2,
        BYP_WB   = 2'd3
    } bypass_sel_t;

    typedef enum logic [1:0] {
        ALU_IN1_REG1 = 2'd0,
        ALU_IN1_PC   = 2'd1,
        ALU_IN1_ZERO = 2'd2
    } alu_in1_sel_t;

    typedef enum logic [1:0] {
        ALU_IN2_REG2 = 2'd0,
        ALU_IN2_IMM  = 2'd1,
        ALU_IN2_FOUR = 2'd2
    } alu_in2_sel_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12,
        ALU_BGE  = 4'd13,
        ALU_BLTU = 4'd14,
        ALU_BGEU = 4'd15
    } alu_op_t;

    typedef struct packed {
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic         rs1_used;
        logic         rs2_used;
        logic         regfile_we;
        logic [31:0]  imm;
        alu_op_t      alu_op;
        alu_in1_sel_t alu_in1_sel;
        alu_in2_sel_t alu_in2_sel;
        logic         is_branch;
        logic         is_jump;
        logic         is_mem_access;
        logic         dcache_wr_enable;
        logic [1:0]   mem_size;
        logic         mem_unsigned;
        logic         is_muldiv;
        logic [2:0]   muldiv_op;
        logic         is_ecall;
        logic         is_csr;
        logic         illegal;
    } decode_out_t;

    // Integer ALU operation from funct3. 'alt' selects SUB/SRA and must
    // already be qualified by the caller, because for OP-IMM bit 30 is
    // immediate data except on the shift-right encoding.
    function automatic alu_op_t alu_func(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_forwarding_decoder.sv
// RV32IM instruction decoder: instr -> decode_out_t control word.
// Latency: 0 cycles, purely combinational.
// Backpressure: none. The output follows instr_i directly.
// Ports: instr_i is the 32-bit instruction word; decode_o is the decoded control word.
module rv32im_decoder
    import decode_forwarding_pkg::*;
(
    input  logic [31:0] instr_i,
    output decode_out_t decode_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        rd_nz;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd_nz  = (instr_i[11:7] != 5'd0);

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'd0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        decode_o             = '0;
        // Register fields are passed through for every encoding, including illegal ones.
        decode_o.rs1         = instr_i[19:15];
        decode_o.rs2         = instr_i[24:20];
        decode_o.rd          = instr_i[11:7];
        decode_o.alu_op      = ALU_ADD;
        decode_o.alu_in1_sel = ALU_IN1_REG1;
        decode_o.alu_in2_sel = ALU_IN2_REG2;

        case (opcode)
            OPC_LUI: begin
                decode_o.regfile_we  = rd_nz;
                decode_o.imm         = imm_u;
                decode_o.alu_in1_sel = ALU_IN1_ZERO;
                decode_o.alu_in2_sel = ALU_IN2_IMM;
            end
            OPC_AUIPC: begin
                decode_o.regfile_we  = rd_nz;
                decode_o.imm         = imm_u;
                decode_o.alu_in1_sel = ALU_IN1_PC;
                decode_o.alu_in2_sel = ALU_IN2_IMM;
            end
            OPC_JAL: begin
                // The ALU produces the target (PC+imm). The link value PC+4 comes from the PC path.
                decode_o.regfile_we  = rd_nz;
                decode_o.is_jump     = 1'b1;
                decode_o.imm         = imm_j;
                decode_o.alu_in1_sel = ALU_IN1_PC;
                decode_o.alu_in2_sel = ALU_IN2_IMM;
            end
            OPC_JALR: begin
                decode_o.regfile_we  = rd_nz;
                decode_o.is_jump     = 1'b1;
                decode_o.rs1_used    = 1'b1;
                decode_o.imm         = imm_i;
                decode_o.alu_in2_sel = ALU_IN2_IMM;
            end
            OPC_BRANCH: begin
                decode_o.is_branch = 1'b1;
                decode_o.rs1_used  = 1'b1;
                decode_o.rs2_used  = 1'b1;
                decode_o.imm       = imm_b;
                case (funct3)
                    3'b001:  decode_o.alu_op = ALU_BNE;
                    3'b100:  decode_o.alu_op = ALU_BLT;
                    3'b101:  decode_o.alu_op = ALU_BGE;
                    3'b110:  decode_o.alu_op = ALU_BLTU;
                    3'b111:  decode_o.alu_op = ALU_BGEU;
                    // Reserved encodings 010/011 fall back to BEQ.
                    default: decode_o.alu_op = ALU_BEQ;
                endcase
            end
            OPC_LOAD: begin
                decode_o.regfile_we    = rd_nz;
                decode_o.rs1_used      = 1'b1;
                decode_o.is_mem_access = 1'b1;
                decode_o.mem_size      = funct3[1:0];
                decode_o.mem_unsigned  = funct3[2];
                decode_o.imm           = imm_i;
                decode_o.alu_in2_sel   = ALU_IN2_IMM;
            end
            OPC_STORE: begin
                decode_o.rs1_used         = 1'b1;
                decode_o.rs2_used         = 1'b1;
                decode_o.is_mem_access    = 1'b1;
                decode_o.dcache_wr_enable = 1'b1;
                decode_o.mem_size         = funct3[1:0];
                decode_o.mem_unsigned     = funct3[2];
                decode_o.imm              = imm_s;
                decode_o.alu_in2_sel      = ALU_IN2_IMM;
            end
            OPC_OP_IMM: begin
                decode_o.regfile_we  = rd_nz;
                decode_o.rs1_used    = 1'b1;
                decode_o.imm         = imm_i;
                decode_o.alu_in2_sel = ALU_IN2_IMM;
                decode_o.alu_op      = alu_func(funct3, (funct3 == 3'b101) & instr_i[30]);
            end
            OPC_OP: begin
                decode_o.regfile_we = rd_nz;
                decode_o.rs1_used   = 1'b1;
                decode_o.rs2_used   = 1'b1;
                if (funct7 == FUNCT7_MULDIV) begin
                    decode_o.is_muldiv = 1'b1;
                    decode_o.muldiv_op = funct3;
                end else begin
                    decode_o.alu_op = alu_func(funct3, funct7[5]);
                end
            end
            OPC_MISC_MEM: begin
                // FENCE/FENCE.I: the in-order pipeline needs no ordering action, so this decodes as a NOP.
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    decode_o.is_ecall = (instr_i == INSTR_ECALL);
                end else begin
                    decode_o.is_csr     = 1'b1;
                    decode_o.regfile_we = rd_nz;
                    // funct3[2] set means the rs1 field carries a 5-bit zimm, not a register.
                    decode_o.rs1_used   = ~funct3[2];
                    decode_o.imm        = imm_i;
                end
            end
            default: begin
                decode_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_forwarding.sv
// ID-stage decode plus operand bypass selection from the EX, MEM and WB stages.
// Latency: 0 cycles. Outputs are combinational from the inputs; reset_i only gates them to zero.
// Backpressure: none. Load hazards are not forwarded, and stalling is left to the hazard unit.
// Ports: clk_i/reset_i (reset_i forces all outputs to zero/NONE); instr_i/id_valid_i for the ID stage;
//        per-stage valid, write enable and write address for EX/MEM/WB, plus is_load for EX/MEM;
//        decode_o is the control word; reg1_bypass_o/reg2_bypass_o are the operand source selects.
module decode_forwarding
    import decode_forwarding_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] instr_i,
    input  logic        id_valid_i,
    input  logic        ex_valid_i,
    input  logic        ex_regfile_we_i,
    input  logic [4:0]  ex_regfile_wr_addr_i,
    input  logic        mem_valid_i,
    input  logic        mem_regfile_we_i,
    input  logic [4:0]  mem_regfile_wr_addr_i,
    input  logic        wb_valid_i,
    input  logic        wb_regfile_we_i,
    input  logic [4:0]  wb_regfile_wr_addr_i,
    input  logic        ex_is_load_i,
    input  logic        mem_is_load_i,
    output decode_out_t decode_o,
    output bypass_sel_t reg1_bypass_o,
    output bypass_sel_t reg2_bypass_o
);

    decode_out_t dec;
    logic        ex_fwd_ok, mem_fwd_ok, wb_fwd_ok;
    logic        rs1_ok, rs2_ok;
    bypass_sel_t byp1, byp2;

    rv32im_decoder u_decoder (
        .instr_i  (instr_i),
        .decode_o (dec)
    );

    // A load in EX or MEM has no data yet. Its consumer must stall instead of taking a stale bypass.
    // By WB the load data exists, so a WB load forwards like any other result.
    assign ex_fwd_ok  = ex_valid_i  & ex_regfile_we_i  & ~ex_is_load_i;
    assign mem_fwd_ok = mem_valid_i & mem_regfile_we_i & ~mem_is_load_i;
    assign wb_fwd_ok  = wb_valid_i  & wb_regfile_we_i;

    // x0 is hard-wired to zero, so a write to x0 never forwards.
    assign rs1_ok = dec.rs1_used & (dec.rs1 != 5'd0);
    assign rs2_ok = dec.rs2_used & (dec.rs2 != 5'd0);

    // The youngest producer wins: EX before MEM before WB.
    always_comb begin
        byp1 = BYP_NONE;
        if (rs1_ok) begin
            if (ex_fwd_ok && (ex_regfile_wr_addr_i == dec.rs1))        byp1 = BYP_EX;
            else if (mem_fwd_ok && (mem_regfile_wr_addr_i == dec.rs1)) byp1 = BYP_MEM;
            else if (wb_fwd_ok && (wb_regfile_wr_addr_i == dec.rs1))   byp1 = BYP_WB;
        end
    end

    always_comb begin
        byp2 = BYP_NONE;
        if (rs2_ok) begin
            if (ex_fwd_ok && (ex_regfile_wr_addr_i == dec.rs2))        byp2 = BYP_EX;
            else if (mem_fwd_ok && (mem_regfile_wr_addr_i == dec.rs2)) byp2 = BYP_MEM;
            else if (wb_fwd_ok && (wb_regfile_wr_addr_i == dec.rs2))   byp2 = BYP_WB;
        end
    end

    // Reset gives a clean NOP. An empty ID slot keeps its decode visible but never selects a bypass.
    always_comb begin
        decode_o      = dec;
        reg1_bypass_o = byp1;
        reg2_bypass_o = byp2;
        if (!id_valid_i) begin
            reg1_bypass_o = BYP_NONE;
            reg2_bypass_o = BYP_NONE;
        end
        if (reset_i) begin
            decode_o      = '0;
            reg1_bypass_o = BYP_NONE;
            reg2_bypass_o = BYP_NONE;
        end
    end

    // Invariant: an EX-stage load is never chosen as a bypass source.
    a_no_ex_load_fwd: assert property (@(posedge clk_i)
        ex_is_load_i |-> (reg1_bypass_o != BYP_EX && reg2_bypass_o != BYP_EX));

endmodule

// File: tb/tb_decode_forwarding.sv
module tb_decode_forwarding;
    import decode_forwarding_pkg::*;

    typedef struct packed {
        logic       v;
        logic       we;
        logic       ld;
        logic [4:0] a;
    } stg_t;

    typedef struct packed {
        int          idx;
        logic        rst;
        logic [4:0]  rs1, rs2, rd;
        logic        rs1_used, rs2_used, we;
        logic        chk_imm;
        logic [31:0] imm;
        logic        chk_sel;
        logic [1:0]  in1, in2;
        logic        br, jmp, mem, dwe;
        logic [1:0]  msz;
        logic        muns;
        logic        md;
        logic [2:0]  mop;
        logic        ecall, csr, ill;
        logic [1:0]  b1, b2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        id_valid = 1'b0;
    stg_t        st_ex = '0, st_mem = '0, st_wb = '0;
    decode_out_t dec_o;
    bypass_sel_t byp1_o, byp2_o;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic drv_done = 1'b0;

    always #5 clk = ~clk;

    decode_forwarding dut (
        .clk_i                 (clk),
        .reset_i               (rst),
        .instr_i               (instr),
        .id_valid_i            (id_valid),
        .ex_valid_i            (st_ex.v),
        .ex_regfile_we_i       (st_ex.we),
        .ex_regfile_wr_addr_i  (st_ex.a),
        .mem_valid_i           (st_mem.v),
        .mem_regfile_we_i      (st_mem.we),
        .mem_regfile_wr_addr_i (st_mem.a),
        .wb_valid_i            (st_wb.v),
        .wb_regfile_we_i       (st_wb.we),
        .wb_regfile_wr_addr_i  (st_wb.a),
        .ex_is_load_i          (st_ex.ld),
        .mem_is_load_i         (st_mem.ld),
        .decode_o              (dec_o),
        .reg1_bypass_o         (byp1_o),
        .reg2_bypass_o         (byp2_o)
    );

    function automatic stg_t mk(input logic v, input logic we, input logic ld, input logic [4:0] a);
        stg_t s;
        s.v = v; s.we = we; s.ld = ld; s.a = a;
        return s;
    endfunction

    // Forwarding reference: scan the producers from youngest to oldest and take the first usable match.
    function automatic logic [1:0] ref_bypass(input logic [4:0] r, input logic used);
        stg_t st[3];
        st[0] = st_ex; st[1] = st_mem; st[2] = st_wb;
        st[2].ld = 1'b0;
        if (!id_valid || !used || r == 5'd0) return 2'd0;
        for (int s = 0; s < 3; s++)
            if (st[s].v && st[s].we && !st[s].ld && st[s].a == r) return 2'(s + 1);
        return 2'd0;
    endfunction

    // Reference decode of the instruction currently driven, following the RV32IM field definitions.
    function automatic exp_t model();
        exp_t        e;
        logic [2:0]  f3;
        logic        rdnz;
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        e = '0;
        e.rst = rst;
        if (rst) return e;
        f3   = instr[14:12];
        rdnz = instr[11:7] != 5'd0;
        iimm = {{20{instr[31]}}, instr[31:20]};
        simm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        bimm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        uimm = {instr[31:12], 12'h000};
        jimm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        e.rs1 = instr[19:15]; e.rs2 = instr[24:20]; e.rd = instr[11:7];
        case (instr[6:0])
            7'b0110111: begin e.we = rdnz; e.chk_imm = 1; e.imm = uimm; e.chk_sel = 1; e.in1 = 2; e.in2 = 1; end
            7'b0010111: begin e.we = rdnz; e.chk_imm = 1; e.imm = uimm; e.chk_sel = 1; e.in1 = 1; e.in2 = 1; end
            7'b1101111: begin e.we = rdnz; e.jmp = 1; e.chk_imm = 1; e.imm = jimm; e.chk_sel = 1; e.in1 = 1; e.in2 = 1; end
            7'b1100111: begin e.we = rdnz; e.jmp = 1; e.rs1_used = 1; e.chk_imm = 1; e.imm = iimm;
                              e.chk_sel = 1; e.in1 = 0; e.in2 = 1; end
            7'b1100011: begin e.br = 1; e.rs1_used = 1; e.rs2_used = 1; e.chk_imm = 1; e.imm = bimm; end
            7'b0000011: begin e.we = rdnz; e.rs1_used = 1; e.mem = 1; e.msz = f3[1:0]; e.muns = f3[2];
                              e.chk_imm = 1; e.imm = iimm; e.chk_sel = 1; e.in1 = 0; e.in2 = 1; end
            7'b0100011: begin e.rs1_used = 1; e.rs2_used = 1; e.mem = 1; e.dwe = 1; e.msz = f3[1:0];
                              e.muns = f3[2]; e.chk_imm = 1; e.imm = simm; e.chk_sel = 1; e.in1 = 0; e.in2 = 1; end
            7'b0010011: begin e.we = rdnz; e.rs1_used = 1; e.chk_imm = 1; e.imm = iimm;
                              e.chk_sel = 1; e.in1 = 0; e.in2 = 1; end
            7'b0110011: begin e.we = rdnz; e.rs1_used = 1; e.rs2_used = 1; e.chk_sel = 1; e.in1 = 0; e.in2 = 0;
                              if (instr[31:25] == 7'b0000001) begin e.md = 1; e.mop = f3; end end
            7'b0001111: begin end
            7'b1110011: begin
                e.ecall = (instr == 32'h0000_0073);
                if (f3 != 3'd0) begin
                    e.csr = 1; e.we = rdnz; e.rs1_used = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3);
                end
            end
            default:    e.ill = 1;
        endcase
        e.b1 = ref_bypass(e.rs1, e.rs1_used);
        e.b2 = ref_bypass(e.rs2, e.rs2_used);
        return e;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic idv, input logic r,
                         input stg_t ex, input stg_t mem, input stg_t wb);
        @(posedge clk);
        #1;
        instr = ins; id_valid = idv; rst = r; st_ex = ex; st_mem = mem; st_wb = wb;
    endtask

    task automatic push(input exp_t e);
        e.idx = vectors;
        vectors++;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input int idx, input logic [95:0] act, input logic [95:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // Monitor: compares the combinational outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.rst) begin
                    chk("reset_decode", e.idx, dec_o, 96'd0);
                    chk("reset_byp1", e.idx, byp1_o, 96'd0);
                    chk("reset_byp2", e.idx, byp2_o, 96'd0);
                end else begin
                    chk("rs1", e.idx, dec_o.rs1, e.rs1);
                    chk("rs2", e.idx, dec_o.rs2, e.rs2);
                    chk("rd", e.idx, dec_o.rd, e.rd);
                    chk("rs1_used", e.idx, dec_o.rs1_used, e.rs1_used);
                    chk("rs2_used", e.idx, dec_o.rs2_used, e.rs2_used);
                    chk("regfile_we", e.idx, dec_o.regfile_we, e.we);
                    if (e.chk_imm) chk("imm", e.idx, dec_o.imm, e.imm);
                    if (e.chk_sel) begin
                        chk("alu_in1_sel", e.idx, dec_o.alu_in1_sel, e.in1);
                        chk("alu_in2_sel", e.idx, dec_o.alu_in2_sel, e.in2);
                    end
                    chk("is_branch", e.idx, dec_o.is_branch, e.br);
                    chk("is_jump", e.idx, dec_o.is_jump, e.jmp);
                    chk("is_mem_access", e.idx, dec_o.is_mem_access, e.mem);
                    chk("dcache_wr_enable", e.idx, dec_o.dcache_wr_enable, e.dwe);
                    if (e.mem) begin
                        chk("mem_size", e.idx, dec_o.mem_size, e.msz);
                        chk("mem_unsigned", e.idx, dec_o.mem_unsigned, e.muns);
                    end
                    chk("is_muldiv", e.idx, dec_o.is_muldiv, e.md);
                    if (e.md) chk("muldiv_op", e.idx, dec_o.muldiv_op, e.mop);
                    chk("is_ecall", e.idx, dec_o.is_ecall, e.ecall);
                    chk("is_csr", e.idx, dec_o.is_csr, e.csr);
                    chk("illegal", e.idx, dec_o.illegal, e.ill);
                    chk("reg1_bypass", e.idx, byp1_o, e.b1);
                    chk("reg2_bypass", e.idx, byp2_o, e.b2);
                end
            end
        end
    end

    // Stimulus: directed corner cases with hand-written key values, then randomized traffic.
    initial begin
        exp_t       e;
        logic [6:0] opcs[11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                                 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
        logic [6:0] bad_opcs[6] = '{7'h7F, 7'h00, 7'h0B, 7'h2B, 7'h5B, 7'h57};
        logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
        stg_t       idle;
        logic [31:0] r;
        int          k;
        idle = '0;

        // Reset dominates even with matching producers and a valid instruction.
        drive(32'h002081B3, 1, 1, mk(1, 1, 0, 1), mk(1, 1, 0, 2), mk(1, 1, 0, 1));
        e = model(); e.rst = 1; push(e);

        drive(32'h002081B3, 1, 0, idle, idle, idle);
        e = model(); e.rs1 = 1; e.rs2 = 2; e.rd = 3; e.we = 1; e.chk_sel = 1; e.in2 = 0; e.md = 0; push(e);

        drive(32'h022081B3, 1, 0, idle, idle, idle);
        e = model(); e.md = 1; e.mop = 0; push(e);

        drive(32'hFE208EE3, 1, 0, idle, idle, idle);
        e = model(); e.br = 1; e.chk_imm = 1; e.imm = 32'hFFFF_FFFC; e.we = 0; push(e);

        drive(32'h002081B3, 1, 0, mk(1, 1, 0, 1), mk(1, 1, 0, 1), idle);
        e = model(); e.b1 = 2'd1; push(e);

        drive(32'h002081B3, 1, 0, mk(0, 1, 0, 1), mk(1, 1, 0, 1), idle);
        e = model(); e.b1 = 2'd2; push(e);

        drive(32'h002081B3, 1, 0, idle, idle, mk(1, 1, 0, 2));
        e = model(); e.b2 = 2'd3; push(e);

        drive(32'h002081B3, 1, 0, mk(1, 1, 1, 2), idle, idle);
        e = model(); e.b2 = 2'd0; push(e);

        drive(32'h002081B3, 1, 0, idle, mk(1, 1, 1, 1), mk(1, 1, 1, 1));
        e = model(); e.b1 = 2'd3; push(e);

        drive(32'h002001B3, 1, 0, mk(1, 1, 0, 0), idle, idle);
        e = model(); e.rs1 = 0; e.b1 = 2'd0; push(e);

        drive(32'h002081B3, 0, 0, mk(1, 1, 0, 1), idle, mk(1, 1, 0, 2));
        e = model(); e.rd = 3; e.we = 1; e.b1 = 2'd0; e.b2 = 2'd0; push(e);

        drive(32'h0000_0073, 1, 0, idle, idle, idle);
        e = model(); e.ecall = 1; e.csr = 0; push(e);

        drive(32'h0000_007F, 1, 0, mk(1, 1, 0, 0), idle, idle);
        e = model(); e.ill = 1; e.we = 0; e.rs1_used = 0; e.rs2_used = 0; push(e);

        for (int n = 0; n < 800; n++) begin
            r = $urandom;
            k = $urandom_range(0, 13);
            if (k <= 10) r[6:0] = opcs[k];
            else if (k == 11) r[6:0] = bad_opcs[$urandom_range(0, 5)];
            else if (k == 12) r = 32'h0000_0073;
            else begin r[6:0] = 7'b0110011; r[31:25] = 7'h01; end
            if (k == 8) r[31:25] = f7s[$urandom_range(0, 2)];
            if (k != 12) begin
                r[19:15] = 5'($urandom_range(0, 3));
                r[24:20] = 5'($urandom_range(0, 3));
            end
            drive(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0),
                  mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3))),
                  mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3))),
                  mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3))));
            push(model());
        end
        drv_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!drv_done && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
        if (!drv_done || sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: done=%0d, %0d expectations left, expected 0", drv_done, sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
